// File: rtl/bnn_seq_classifier.sv
// bnn_seq_classifier: time-multiplexed binarised neural network classifier.
// Accepts one feature vector per in_valid/in_ready handshake and binarises each feature against
// THRESH. It then evaluates one hidden neuron per cycle and one output class per cycle using
// XNOR-popcount. The argmax class, its score and the hidden activations are returned over an
// out_valid/out_ready handshake. Results are held until the next result is produced.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ena               clock enable; low freezes all state and blocks both handshakes
//   in_valid/in_ready input handshake; in_feat carries feature i at [i*IN_W +: IN_W]
//   out_valid/out_ready output handshake
//   out_class         winning class index (ties go to the lowest index)
//   out_score         winning class popcount
//   out_hidden        hidden activations, bit h = neuron h
//   busy              high whenever a vector is in flight or a result awaits consumption
module bnn_seq_classifier #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned IN_W   = 4,
    parameter int unsigned THRESH = 8,
    parameter int unsigned N_HID  = 4,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned BW     = 4,
    parameter logic [N_HID*N_IN-1:0]  W_IH = '0,
    parameter logic [N_HID*BW-1:0]    B_H  = '0,
    parameter logic [N_OUT*N_HID-1:0] W_HO = '0,
    localparam int unsigned CW = (N_OUT > 2) ? $clog2(N_OUT) : 1,
    localparam int unsigned SW = $clog2(N_HID + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_feat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_class,
    output logic [SW-1:0]        out_score,
    output logic [N_HID-1:0]     out_hidden,
    output logic                 busy
);

    localparam int unsigned PW   = $clog2(N_IN + 1);
    localparam int unsigned SUMW = ((PW > BW) ? PW : BW) + 1;
    localparam int unsigned HW   = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam logic [HW-1:0] HLast = HW'(N_HID - 1);
    localparam logic [CW-1:0] CLast = CW'(N_OUT - 1);

    typedef enum logic [1:0] {StIdle, StHid, StOut, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   xb_q, xb_d;
    logic [N_HID-1:0]  hid_q, hid_d;
    logic [HW-1:0]     h_q, h_d;
    logic [CW-1:0]     c_q, c_d;
    logic [SW-1:0]     max_q, max_d;
    logic [CW-1:0]     arg_q, arg_d;
    logic [CW-1:0]     cls_q, cls_d;
    logic [SW-1:0]     score_q, score_d;
    logic [N_HID-1:0]  hout_q, hout_d;

    logic [N_IN-1:0]   xb_in;
    logic [N_IN-1:0]   w_row;
    logic [BW-1:0]     b_row;
    logic [N_HID-1:0]  ho_row;
    logic [PW-1:0]     p;
    logic [SUMW-1:0]   sum;
    logic              hid_bit;
    logic [SW-1:0]     q;
    logic              take;
    logic [SW-1:0]     max_new;
    logic [CW-1:0]     arg_new;

    // Binarisation of the incoming vector.
    always_comb begin
        xb_in = '0;
        for (int i = 0; i < N_IN; i++) begin
            xb_in[i] = (32'(in_feat[i*IN_W +: IN_W]) >= THRESH);
        end
    end

    // Weight/bias row selection by the current neuron/class counters.
    always_comb begin
        w_row  = '0;
        b_row  = '0;
        ho_row = '0;
        for (int k = 0; k < N_HID; k++) begin
            if (int'(h_q) == k) begin
                w_row = W_IH[k*N_IN +: N_IN];
                b_row = B_H[k*BW +: BW];
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (int'(c_q) == k) begin
                ho_row = W_HO[k*N_HID +: N_HID];
            end
        end
    end

    // Hidden neuron: XNOR-popcount plus signed bias; sum is wide enough to never overflow.
    always_comb begin
        p = '0;
        for (int i = 0; i < N_IN; i++) begin
            p = p + PW'(~(xb_q[i] ^ w_row[i]));
        end
        sum     = {{(SUMW - PW){1'b0}}, p} + {{(SUMW - BW){b_row[BW-1]}}, b_row};
        hid_bit = ~sum[SUMW-1];
    end

    // Output class: XNOR-popcount and running argmax (strict compare keeps the lowest index).
    always_comb begin
        q = '0;
        for (int i = 0; i < N_HID; i++) begin
            q = q + SW'(~(hid_q[i] ^ ho_row[i]));
        end
        take    = (c_q == '0) || (q > max_q);
        max_new = take ? q : max_q;
        arg_new = take ? c_q : arg_q;
    end

    always_comb begin
        state_d = state_q;
        xb_d    = xb_q;
        hid_d   = hid_q;
        h_d     = h_q;
        c_d     = c_q;
        max_d   = max_q;
        arg_d   = arg_q;
        cls_d   = cls_q;
        score_d = score_q;
        hout_d  = hout_q;
        if (ena) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        xb_d    = xb_in;
                        hid_d   = '0;
                        h_d     = '0;
                        state_d = StHid;
                    end
                end
                StHid: begin
                    hid_d[h_q] = hid_bit;
                    if (h_q == HLast) begin
                        c_d     = '0;
                        max_d   = '0;
                        arg_d   = '0;
                        state_d = StOut;
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end
                StOut: begin
                    max_d = max_new;
                    arg_d = arg_new;
                    if (c_q == CLast) begin
                        cls_d   = arg_new;
                        score_d = max_new;
                        hout_d  = hid_q;
                        state_d = StDone;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            xb_q    <= '0;
            hid_q   <= '0;
            h_q     <= '0;
            c_q     <= '0;
            max_q   <= '0;
            arg_q   <= '0;
            cls_q   <= '0;
            score_q <= '0;
            hout_q  <= '0;
        end else begin
            state_q <= state_d;
            xb_q    <= xb_d;
            hid_q   <= hid_d;
            h_q     <= h_d;
            c_q     <= c_d;
            max_q   <= max_d;
            arg_q   <= arg_d;
            cls_q   <= cls_d;
            score_q <= score_d;
            hout_q  <= hout_d;
        end
    end

    assign in_ready   = ena && (state_q == StIdle);
    assign out_valid  = ena && (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign out_class  = cls_q;
    assign out_score  = score_q;
    assign out_hidden = hout_q;

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Directed self-checking bench for bnn_seq_classifier.
// Configuration: 4 features, 4 hidden, 4 classes, all hidden biases -2, all hidden rows 1111,
// output rows c0=0000 c1=1111 c2=1100 c3=1111.
module tb_bnn_seq_classifier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_feat;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_class;
    logic [2:0]  out_score;
    logic [3:0]  out_hidden;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bnn_seq_classifier #(
        .N_IN  (4),
        .IN_W  (4),
        .THRESH(8),
        .N_HID (4),
        .N_OUT (4),
        .BW    (4),
        .W_IH  (16'hFFFF),
        .B_H   (16'hEEEE),
        .W_HO  (16'hFCF0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .out_hidden(out_hidden),
        .busy      (busy)
    );

    // Present a vector and let the accept edge pass; returns #1 after that edge.
    task automatic accept(input logic [15:0] feat);
        in_feat  = feat;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_feat = '0;
        #12;
        total_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_hs got %b want 100", {in_ready, out_valid, busy});
        else pass_cnt++;
        total_cnt++;
        if ({out_class, out_score, out_hidden} !== 9'd0) $display("FAIL reset_out got %h want 0", {out_class, out_score, out_hidden});
        else pass_cnt++;
        ena = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_ready_ena got %b want 0", in_ready);
        else pass_cnt++;
        ena = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 0;
    endtask

    task automatic test_all_high();
        int lat;
        accept(16'hFFFF);
        total_cnt++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL high_busy got %b want 10", {busy, in_ready});
        else pass_cnt++;
        wait_out(lat);
        total_cnt++;
        if (lat !== 8) $display("FAIL high_latency got %0d want 8", lat);
        else pass_cnt++;
        total_cnt++;
        if ({out_class, out_score, out_hidden} !== {2'd1, 3'd4, 4'hF})
            $display("FAIL high_result got c=%0d s=%0d h=%b want c=1 s=4 h=1111", out_class, out_score, out_hidden);
        else pass_cnt++;
        consume();
        total_cnt++;
        if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL high_consume got %b want 010", {out_valid, in_ready, busy});
        else pass_cnt++;
        total_cnt++;
        if ({out_class, out_score} !== {2'd1, 3'd4}) $display("FAIL high_hold got c=%0d s=%0d want c=1 s=4", out_class, out_score);
        else pass_cnt++;
    endtask

    task automatic test_all_low();
        int lat;
        accept(16'h0000);
        wait_out(lat);
        total_cnt++;
        if (lat !== 8) $display("FAIL low_latency got %0d want 8", lat);
        else pass_cnt++;
        total_cnt++;
        if ({out_class, out_score, out_hidden} !== {2'd0, 3'd4, 4'h0})
            $display("FAIL low_result got c=%0d s=%0d h=%b want c=0 s=4 h=0000", out_class, out_score, out_hidden);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_threshold();
        int lat;
        accept(16'h7878);  // f0=8 f1=7 f2=8 f3=7
        wait_out(lat);
        total_cnt++;
        if ({out_class, out_score, out_hidden} !== {2'd1, 3'd4, 4'hF})
            $display("FAIL thresh_result got c=%0d s=%0d h=%b want c=1 s=4 h=1111", out_class, out_score, out_hidden);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        accept(16'hFFFF);
        wait_out(lat);
        in_feat  = 16'h0000;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if ({out_valid, in_ready, out_class, out_score, out_hidden} !== {1'b1, 1'b0, 2'd1, 3'd4, 4'hF})
                bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles want 0", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL bp_release got %b want 010", {out_valid, in_ready, busy});
        else pass_cnt++;
        in_valid = 1'b0;
        total_cnt++;
        if (out_class !== 2'd1) $display("FAIL bp_not_taken got c=%0d want 1", out_class);
        else pass_cnt++;
    endtask

    task automatic test_ena_stall();
        int lat = 0;
        accept(16'hFFFF);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            ena = !(lat >= 5 && lat < 8);
        end
        ena = 1'b1;
        total_cnt++;
        if (lat !== 11) $display("FAIL ena_latency got %0d want 11", lat);
        else pass_cnt++;
        total_cnt++;
        if ({out_class, out_score, out_hidden} !== {2'd1, 3'd4, 4'hF})
            $display("FAIL ena_result got c=%0d s=%0d h=%b want c=1 s=4 h=1111", out_class, out_score, out_hidden);
        else pass_cnt++;
        ena       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, in_ready, busy} !== 3'b001) $display("FAIL ena_block got %b want 001", {out_valid, in_ready, busy});
        else pass_cnt++;
        ena = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({in_ready, busy} !== 2'b10) $display("FAIL ena_resume got %b want 10", {in_ready, busy});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        accept(16'hFFFF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, busy, out_class, out_score, out_hidden} !== 11'd0)
            $display("FAIL rst_mid got v=%b b=%b c=%0d s=%0d h=%b want all 0", out_valid, busy, out_class, out_score, out_hidden);
        else pass_cnt++;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        accept(16'h0000);
        wait_out(lat);
        total_cnt++;
        if (lat !== 8) $display("FAIL rst_relat got %0d want 8", lat);
        else pass_cnt++;
        total_cnt++;
        if ({out_class, out_score, out_hidden} !== {2'd0, 3'd4, 4'h0})
            $display("FAIL rst_result got c=%0d s=%0d h=%b want c=0 s=4 h=0000", out_class, out_score, out_hidden);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        accept(16'hFFFF);
        in_feat  = 16'h0000;
        in_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) begin
                total_cnt++;
                if (!(out_valid === 1'b1 && out_class === 2'd1)) $display("FAIL b2b_first got v=%b c=%0d want v=1 c=1", out_valid, out_class);
                else pass_cnt++;
            end
            if (k == 9) begin
                total_cnt++;
                if (in_ready !== 1'b1) $display("FAIL b2b_idle got %b want 1", in_ready);
                else pass_cnt++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL b2b_accept2 got %b want 1", busy);
        else pass_cnt++;
        wait_out(lat);
        total_cnt++;
        if (lat !== 8 || out_class !== 2'd0) $display("FAIL b2b_second got lat=%0d c=%0d want lat=8 c=0", lat, out_class);
        else pass_cnt++;
        consume();
    endtask

    initial begin
        test_reset();
        test_all_high();
        test_all_low();
        test_threshold();
        test_backpressure();
        test_ena_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
